// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream arbiter with packet-granularity round-robin.
// The granted input owns the output until its tlast beat is accepted; the data path is purely combinational.
module axis_packet_arbiter #(
    parameter int NUM_INPUTS     = 2,
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1
) (
    input  logic                                 clk,
    input  logic                                 sreset,
    output logic [NUM_INPUTS-1:0]                axis_i_tready,
    input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
    input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
    input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic [NUM_INPUTS-1:0]                axis_i_error,
    input  logic                                 axis_o_tready,
    output logic                                 axis_o_tvalid,
    output logic                                 axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
    output logic                                 axis_o_error,
    output logic [NUM_INPUTS-1:0]                grant,
    output logic                                 busy
);

    localparam int DW    = AXIS_BYTES * 8;
    localparam int UW    = AXIS_USER_BITS;
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_sel;
    logic [SEL_W-1:0]        r_rr_ptr;
    logic [NUM_INPUTS-1:0]   r_grant;
    logic                    r_busy;

    logic                    w_found;
    logic [SEL_W-1:0]        w_pick;
    logic [NUM_INPUTS-1:0]   w_pick_oh;
    logic                    w_done;
    int unsigned             w_idx;

    // Round-robin search: first valid input at or above rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            w_idx = 32'(r_rr_ptr) + i;
            if (w_idx >= NUM_INPUTS) begin
                w_idx = w_idx - NUM_INPUTS;
            end
            if (!w_found && axis_i_tvalid[SEL_W'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'(w_idx);
            end
        end
    end

    assign w_pick_oh = NUM_INPUTS'(1) << w_pick;

    always_comb begin
        axis_i_tready = '0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = axis_i_tlast[r_sel];
        axis_o_tdata  = axis_i_tdata[int'(r_sel) * DW +: DW];
        axis_o_tuser  = axis_i_tuser[int'(r_sel) * UW +: UW];
        axis_o_error  = axis_i_error[r_sel];
        if (r_state == ST_BUSY) begin
            axis_o_tvalid        = axis_i_tvalid[r_sel];
            axis_i_tready[r_sel] = axis_o_tready;
        end
    end

    assign w_done = axis_o_tvalid & axis_o_tready & axis_o_tlast;

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_BUSY;
                        r_sel   <= w_pick;
                        r_grant <= w_pick_oh;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state  <= ST_IDLE;
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter with 3 inputs of 1 byte each.
// Each vector drives one cycle of inputs and states the outputs expected before the next clock edge.
module tb_axis_packet_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          sreset;
    logic [N-1:0]  axis_i_tready;
    logic [N-1:0]  axis_i_tvalid;
    logic [N-1:0]  axis_i_tlast;
    logic [N*8-1:0] axis_i_tdata;
    logic [N-1:0]  axis_i_tuser;
    logic [N-1:0]  axis_i_error;
    logic          axis_o_tready;
    logic          axis_o_tvalid;
    logic          axis_o_tlast;
    logic [7:0]    axis_o_tdata;
    logic [0:0]    axis_o_tuser;
    logic          axis_o_error;
    logic [N-1:0]  grant;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    axis_packet_arbiter #(
        .NUM_INPUTS     (N),
        .AXIS_BYTES     (1),
        .AXIS_USER_BITS (1)
    ) dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (axis_i_tready),
        .axis_i_tvalid (axis_i_tvalid),
        .axis_i_tlast  (axis_i_tlast),
        .axis_i_tdata  (axis_i_tdata),
        .axis_i_tuser  (axis_i_tuser),
        .axis_i_error  (axis_i_error),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tlast  (axis_o_tlast),
        .axis_o_tdata  (axis_o_tdata),
        .axis_o_tuser  (axis_o_tuser),
        .axis_o_error  (axis_o_error),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit [2:0]  tv;
        bit [2:0]  tl;
        bit [23:0] td;
        bit [2:0]  tu;
        bit [2:0]  er;
        bit        ordy;
        bit        ev;
        bit        el;
        bit [7:0]  ed;
        bit        eu;
        bit        ee;
        bit [2:0]  etr;
        bit [2:0]  eg;
        bit        eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(input bit rst, input bit [2:0] tv, input bit [2:0] tl,
                                input bit [23:0] td, input bit [2:0] tu, input bit [2:0] er,
                                input bit ordy, input bit ev, input bit el, input bit [7:0] ed,
                                input bit eu, input bit ee, input bit [2:0] etr,
                                input bit [2:0] eg, input bit eb);
        vec_t v;
        v.rst = rst; v.tv = tv; v.tl = tl; v.td = td; v.tu = tu; v.er = er; v.ordy = ordy;
        v.ev = ev; v.el = el; v.ed = ed; v.eu = eu; v.ee = ee; v.etr = etr; v.eg = eg; v.eb = eb;
        return v;
    endfunction

    // Expected-idle shorthand: no output beat, no tready, no grant.
    function automatic vec_t mi(input bit rst, input bit [2:0] tv, input bit [2:0] tl,
                                input bit [23:0] td, input bit ordy);
        return mv(rst, tv, tl, td, 3'b000, 3'b000, ordy, 0, 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        sreset        = v.rst;
        axis_i_tvalid = v.tv;
        axis_i_tlast  = v.tl;
        axis_i_tdata  = v.td;
        axis_i_tuser  = v.tu;
        axis_i_error  = v.er;
        axis_o_tready = v.ordy;
        #1;
        chk("tvalid", idx, 32'(axis_o_tvalid), 32'(v.ev));
        chk("tready", idx, 32'(axis_i_tready), 32'(v.etr));
        chk("grant",  idx, 32'(grant),         32'(v.eg));
        chk("busy",   idx, 32'(busy),          32'(v.eb));
        if (v.ev) begin
            chk("tdata", idx, 32'(axis_o_tdata), 32'(v.ed));
            chk("tlast", idx, 32'(axis_o_tlast), 32'(v.el));
            chk("tuser", idx, 32'(axis_o_tuser), 32'(v.eu));
            chk("error", idx, 32'(axis_o_error), 32'(v.ee));
        end
    endtask

    initial begin
        sreset        = 1'b1;
        axis_i_tvalid = '0;
        axis_i_tlast  = '0;
        axis_i_tdata  = '0;
        axis_i_tuser  = '0;
        axis_i_error  = '0;
        axis_o_tready = 1'b0;
        @(negedge clk);

        // Reset held with every input valid, then one cycle after release.
        for (int i = 0; i < 3; i++) vecs.push_back(mi(1, 3'b111, 3'b000, 24'h201000, 1));
        vecs.push_back(mi(0, 3'b111, 3'b000, 24'h201000, 1));
        // Round-robin over 2-beat packets (input 1 carries tuser=1); two full rounds.
        for (int r = 0; r < 2; r++) begin
            if (r != 0) vecs.push_back(mi(0, 3'b111, 3'b000, 24'h201000, 1));
            vecs.push_back(mv(0, 3'b111, 3'b000, 24'h201000, 3'b010, 3'b000, 1, 1, 0, 8'h00, 0, 0, 3'b001, 3'b001, 1));
            vecs.push_back(mv(0, 3'b111, 3'b001, 24'h201001, 3'b010, 3'b000, 1, 1, 1, 8'h01, 0, 0, 3'b001, 3'b001, 1));
            vecs.push_back(mi(0, 3'b111, 3'b000, 24'h201000, 1));
            vecs.push_back(mv(0, 3'b111, 3'b000, 24'h201000, 3'b010, 3'b000, 1, 1, 0, 8'h10, 1, 0, 3'b010, 3'b010, 1));
            vecs.push_back(mv(0, 3'b111, 3'b010, 24'h201100, 3'b010, 3'b000, 1, 1, 1, 8'h11, 1, 0, 3'b010, 3'b010, 1));
            vecs.push_back(mi(0, 3'b111, 3'b000, 24'h201000, 1));
            vecs.push_back(mv(0, 3'b111, 3'b000, 24'h201000, 3'b010, 3'b000, 1, 1, 0, 8'h20, 0, 0, 3'b100, 3'b100, 1));
            vecs.push_back(mv(0, 3'b111, 3'b100, 24'h211000, 3'b010, 3'b000, 1, 1, 1, 8'h21, 0, 0, 3'b100, 3'b100, 1));
        end
        vecs.push_back(mi(0, 3'b000, 3'b000, 24'h000000, 1));
        // Error flag on the middle beat of a 3-beat packet from input 0.
        vecs.push_back(mi(0, 3'b001, 3'b000, 24'h0000A0, 1));
        vecs.push_back(mv(0, 3'b001, 3'b000, 24'h0000A0, 3'b000, 3'b000, 1, 1, 0, 8'hA0, 0, 0, 3'b001, 3'b001, 1));
        vecs.push_back(mv(0, 3'b001, 3'b000, 24'h0000A1, 3'b001, 3'b001, 1, 1, 0, 8'hA1, 1, 1, 3'b001, 3'b001, 1));
        vecs.push_back(mv(0, 3'b001, 3'b001, 24'h0000A2, 3'b000, 3'b000, 1, 1, 1, 8'hA2, 0, 0, 3'b001, 3'b001, 1));
        vecs.push_back(mi(0, 3'b000, 3'b000, 24'h000000, 1));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Input 1 gaps mid-packet while input 2 waits with a single-beat packet.
        step(mi(0, 3'b110, 3'b100, 24'h2F1000, 1), 100);
        step(mv(0, 3'b110, 3'b100, 24'h2F1000, 3'b000, 3'b000, 1, 1, 0, 8'h10, 0, 0, 3'b010, 3'b010, 1), 101);
        step(mv(0, 3'b110, 3'b100, 24'h2F1100, 3'b000, 3'b000, 1, 1, 0, 8'h11, 0, 0, 3'b010, 3'b010, 1), 102);
        step(mv(0, 3'b100, 3'b100, 24'h2F1200, 3'b000, 3'b000, 1, 0, 0, 8'h00, 0, 0, 3'b010, 3'b010, 1), 103);
        step(mv(0, 3'b100, 3'b100, 24'h2F1200, 3'b000, 3'b000, 1, 0, 0, 8'h00, 0, 0, 3'b010, 3'b010, 1), 104);
        step(mv(0, 3'b110, 3'b100, 24'h2F1200, 3'b000, 3'b000, 1, 1, 0, 8'h12, 0, 0, 3'b010, 3'b010, 1), 105);
        step(mv(0, 3'b110, 3'b110, 24'h2F1300, 3'b000, 3'b000, 1, 1, 1, 8'h13, 0, 0, 3'b010, 3'b010, 1), 106);
        step(mi(0, 3'b100, 3'b100, 24'h2F0000, 1), 107);
        step(mv(0, 3'b100, 3'b100, 24'h2F0000, 3'b000, 3'b000, 1, 1, 1, 8'h2F, 0, 0, 3'b100, 3'b100, 1), 108);
        step(mi(0, 3'b000, 3'b000, 24'h000000, 1), 109);

        // Downstream backpressure toggling during a 3-beat packet from input 0.
        step(mi(0, 3'b001, 3'b000, 24'h0000B0, 1), 200);
        step(mv(0, 3'b001, 3'b000, 24'h0000B0, 3'b000, 3'b000, 1, 1, 0, 8'hB0, 0, 0, 3'b001, 3'b001, 1), 201);
        step(mv(0, 3'b001, 3'b000, 24'h0000B1, 3'b000, 3'b000, 0, 1, 0, 8'hB1, 0, 0, 3'b000, 3'b001, 1), 202);
        step(mv(0, 3'b001, 3'b000, 24'h0000B1, 3'b000, 3'b000, 1, 1, 0, 8'hB1, 0, 0, 3'b001, 3'b001, 1), 203);
        step(mv(0, 3'b001, 3'b001, 24'h0000B2, 3'b000, 3'b000, 0, 1, 1, 8'hB2, 0, 0, 3'b000, 3'b001, 1), 204);
        step(mv(0, 3'b001, 3'b001, 24'h0000B2, 3'b000, 3'b000, 1, 1, 1, 8'hB2, 0, 0, 3'b001, 3'b001, 1), 205);
        step(mi(0, 3'b000, 3'b000, 24'h000000, 0), 206);

        // Reset mid-packet from input 2, then restart from pointer 0 and wrap after input 2.
        step(mi(0, 3'b100, 3'b000, 24'hC00000, 1), 300);
        step(mv(0, 3'b100, 3'b000, 24'hC00000, 3'b000, 3'b000, 1, 1, 0, 8'hC0, 0, 0, 3'b100, 3'b100, 1), 301);
        step(mv(0, 3'b100, 3'b000, 24'hC10000, 3'b000, 3'b000, 1, 1, 0, 8'hC1, 0, 0, 3'b100, 3'b100, 1), 302);
        step(mv(1, 3'b100, 3'b000, 24'hC20000, 3'b000, 3'b000, 1, 1, 0, 8'hC2, 0, 0, 3'b100, 3'b100, 1), 303);
        step(mi(0, 3'b101, 3'b001, 24'hC300D0, 1), 304);
        step(mv(0, 3'b101, 3'b001, 24'hC300D0, 3'b000, 3'b000, 1, 1, 1, 8'hD0, 0, 0, 3'b001, 3'b001, 1), 305);
        step(mi(0, 3'b100, 3'b000, 24'hC30000, 1), 306);
        step(mv(0, 3'b100, 3'b000, 24'hC30000, 3'b000, 3'b000, 1, 1, 0, 8'hC3, 0, 0, 3'b100, 3'b100, 1), 307);
        step(mv(0, 3'b100, 3'b100, 24'hC40000, 3'b000, 3'b000, 1, 1, 1, 8'hC4, 0, 0, 3'b100, 3'b100, 1), 308);
        step(mi(0, 3'b011, 3'b011, 24'h00E1E0, 1), 309);
        step(mv(0, 3'b011, 3'b011, 24'h00E1E0, 3'b000, 3'b000, 1, 1, 1, 8'hE0, 0, 0, 3'b001, 3'b001, 1), 310);
        step(mi(0, 3'b010, 3'b010, 24'h00E100, 1), 311);
        step(mv(0, 3'b010, 3'b010, 24'h00E100, 3'b000, 3'b000, 1, 1, 1, 8'hE1, 0, 0, 3'b010, 3'b010, 1), 312);
        step(mi(0, 3'b000, 3'b000, 24'h000000, 1), 313);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
